// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues one imem request at a time,
// and feeds decode through the IF/ID register with a one-entry skid buffer.
module if_stage #(
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter int                         INST_DATA_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_in,
  input  logic                       branch_en,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ready,
  input  logic                       imem_rvalid,
  input  logic [INST_DATA_WIDTH-1:0] imem_rdata,
  output logic                       inst_valid,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  output logic [INST_DATA_WIDTH-1:0] inst_data_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                     r_state;
  logic [INST_ADDR_WIDTH-1:0] r_pc;
  logic [INST_ADDR_WIDTH-1:0] r_req_pc;
  logic                       r_kill;
  logic                       r_skid_vld;
  logic [INST_ADDR_WIDTH-1:0] r_skid_pc;
  logic [INST_DATA_WIDTH-1:0] r_skid_data;
  logic                       r_inst_valid;
  logic [INST_ADDR_WIDTH-1:0] r_inst_pc;
  logic [INST_DATA_WIDTH-1:0] r_inst_data;

  logic                       w_accept;
  logic                       w_live;
  logic                       w_load;
  logic [INST_ADDR_WIDTH-1:0] w_target;
  logic [INST_ADDR_WIDTH-1:0] w_pc_inc;

  assign w_accept = (r_state == S_REQ) && imem_ready;
  // A live response is one the fetch stage will actually keep (not killed).
  assign w_live   = (r_state == S_WAIT) && imem_rvalid && !r_kill;
  assign w_load   = !r_inst_valid || !stall_in;
  assign w_target = branch_target & ~{{(INST_ADDR_WIDTH-2){1'b0}}, 2'b11};
  assign w_pc_inc = r_pc + {{(INST_ADDR_WIDTH-3){1'b0}}, 3'd4};

  assign imem_req      = (r_state == S_REQ);
  assign imem_addr     = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst_pc       = r_inst_pc;
  assign inst_data_out = r_inst_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_pc     <= '0;
      r_kill       <= 1'b0;
      r_skid_vld   <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_data  <= '0;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
      r_inst_data  <= '0;
    end else if (branch_en) begin
      r_pc         <= w_target;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
      r_inst_data  <= '0;
      r_skid_vld   <= 1'b0;
      // A request still owed a response must have that response swallowed.
      if (w_accept || (r_state == S_WAIT && !imem_rvalid)) begin
        r_state <= S_WAIT;
        r_kill  <= 1'b1;
      end else begin
        r_state <= S_REQ;
        r_kill  <= 1'b0;
      end
    end else begin
      if (w_load) begin
        if (r_skid_vld) begin
          r_inst_valid <= 1'b1;
          r_inst_pc    <= r_skid_pc;
          r_inst_data  <= r_skid_data;
          r_skid_vld   <= 1'b0;
        end else if (w_live) begin
          r_inst_valid <= 1'b1;
          r_inst_pc    <= r_req_pc;
          r_inst_data  <= imem_rdata;
        end else begin
          r_inst_valid <= 1'b0;
          r_inst_data  <= '0;
        end
      end else if (w_live) begin
        r_skid_vld  <= 1'b1;
        r_skid_pc   <= r_req_pc;
        r_skid_data <= imem_rdata;
      end

      case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            r_req_pc <= r_pc;
            r_pc     <= w_pc_inc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_kill  <= 1'b0;
            r_state <= (w_live && !w_load) ? S_HOLD : S_REQ;
          end
        end
        S_HOLD: begin
          if (w_load) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-configurable memory responder and a
// scoreboard of expected {pc, data} pairs consumed as decode accepts them.
module tb_if_stage;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data_out;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] exp_pc;
  int          lat;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_pc       (inst_pc),
    .inst_data_out (inst_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock: score decode consumption, model requests/redirects, then
  // advance the memory responder after the edge.
  task automatic tick();
    logic acc;
    exp_t e;
    if (inst_valid && !stall_in) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_data", inst_data_out, e.data);
      end
    end
    if (!inst_valid) chk("nop_when_invalid", inst_data_out, 32'd0);
    acc = imem_req && imem_ready;
    if (acc) begin
      chk("req_addr", imem_addr, exp_pc);
      e.pc   = exp_pc;
      e.data = exp_pc ^ MASK;
      sb.push_back(e);
      exp_pc = exp_pc + 32'd4;
      m_addr = imem_addr;
    end
    if (branch_en) begin
      sb.delete();
      exp_pc = branch_target & ~32'd3;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (acc) begin
      m_pend = 1'b1;
      m_cnt  = lat;
    end
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_addr ^ MASK;
        m_pend      = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    stall_in      = 1'b0;
    branch_en     = 1'b0;
    branch_target = '0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    lat           = 1;
    m_pend        = 1'b0;
    m_cnt         = 0;
    m_addr        = '0;
    exp_pc        = 32'h0;

    #2;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data_out, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);

    // zero-wait stream
    imem_ready = 1'b1;
    tick();
    tick();
    chk("seq0_valid", 32'(inst_valid), 32'd1);
    chk("seq0_pc", inst_pc, 32'h0);
    chk("seq0_data", inst_data_out, 32'hA5A5_0000);
    tick();
    chk("seq_gap_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("seq4_valid", 32'(inst_valid), 32'd1);
    chk("seq4_pc", inst_pc, 32'h4);

    // stall while @4 is held; @8 lands in the skid buffer
    stall_in = 1'b1;
    tick();
    chk("stall_wait_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold_req", 32'(imem_req), 32'd0);
      chk("stall_hold_pc", inst_pc, 32'h4);
      chk("stall_hold_data", inst_data_out, 32'h4 ^ MASK);
    end
    stall_in = 1'b0;
    tick();
    chk("skid_drain_valid", 32'(inst_valid), 32'd1);
    chk("skid_drain_pc", inst_pc, 32'h8);
    chk("skid_drain_req", 32'(imem_req), 32'd1);
    chk("skid_drain_addr", imem_addr, 32'hC);
    tick();
    tick();
    chk("resume_pc", inst_pc, 32'hC);

    // redirect while a slow response is outstanding
    lat = 3;
    tick();
    chk("br_wait_req", 32'(imem_req), 32'd0);
    branch_en     = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_en = 1'b0;
    lat       = 1;
    chk("br_inst_valid", 32'(inst_valid), 32'd0);
    chk("br_addr", imem_addr, 32'h100);
    wait_valid("br_wait_valid");
    chk("br_first_pc", inst_pc, 32'h100);
    chk("br_first_data", inst_data_out, 32'h100 ^ MASK);

    // redirect with stall and a full skid buffer
    stall_in = 1'b1;
    tick();
    tick();
    chk("skidfull_req", 32'(imem_req), 32'd0);
    branch_en     = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    branch_en = 1'b0;
    chk("skidbr_valid", 32'(inst_valid), 32'd0);
    chk("skidbr_data", inst_data_out, 32'd0);
    chk("skidbr_req", 32'(imem_req), 32'd1);
    chk("skidbr_addr", imem_addr, 32'h200);
    stall_in = 1'b0;
    wait_valid("skidbr_wait_valid");
    chk("skidbr_pc", inst_pc, 32'h200);

    // pc wrap at the top of the address space
    branch_en     = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_en = 1'b0;
    wait_valid("wrap_wait_valid");
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // asynchronous reset mid-WAIT with a held instruction
    stall_in = 1'b1;
    lat      = 3;
    tick();
    chk("prerst_req", 32'(imem_req), 32'd0);
    chk("prerst_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_pc", inst_pc, 32'd0);
    chk("arst_data", inst_data_out, 32'd0);
    chk("arst_req", 32'(imem_req), 32'd1);
    chk("arst_addr", imem_addr, 32'h0);
    m_pend      = 1'b0;
    imem_rvalid = 1'b0;
    sb.delete();
    exp_pc      = 32'h0;
    imem_ready  = 1'b0;
    stall_in    = 1'b0;
    lat         = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdylow_req", 32'(imem_req), 32'd1);
      chk("rdylow_addr", imem_addr, 32'h0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("late_rvalid_ignored", 32'(inst_valid), 32'd0);
    imem_ready = 1'b1;
    wait_valid("postrst_wait_valid");
    chk("postrst_pc", inst_pc, 32'h0);
    chk("postrst_data", inst_data_out, MASK);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
